// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the write-back entry type used between
// the execute units and the register-file write port.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering long-latency results until the write port is free.
// Push is ignored when full and pop is ignored when empty.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  wb_entry                  push_data,
  input  logic                     pop,
  output wb_entry                  head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  wb_entry        mem [DEPTH];
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_seq.sv
// Write-back sequencer: arbitrates ALU and buffered long-latency results onto
// the single register-file write port and tracks pending destinations.
module regfile_wb_seq
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [REG_AW-1:0]        alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [REG_AW-1:0]        lsu_rd,
  input  logic [XLEN-1:0]          lsu_data,
  input  logic                     iss_valid,
  input  logic [REG_AW-1:0]        iss_rd,
  output logic                     rf_we,
  output logic [REG_AW-1:0]        rf_rw,
  output logic [XLEN-1:0]          rf_busw,
  output logic [NREGS-1:0]         busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  wb_entry          fifo_head;
  wb_entry          fifo_in;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             alu_sel;
  logic             fifo_wr;
  logic             iss_set;
  logic [NREGS-1:0] busy_next;

  // ALU writes to x0 are dropped so they do not block the FIFO from draining.
  assign alu_sel   = alu_valid && (alu_rd != '0);
  assign fifo_pop  = !alu_sel && !fifo_empty;
  assign fifo_wr   = fifo_pop && (fifo_head.rd != '0);
  assign iss_set   = iss_valid && (iss_rd != '0);
  assign lsu_ready = !fifo_full;
  assign fifo_push = lsu_valid && lsu_ready;
  assign fifo_in   = '{rd: lsu_rd, data: lsu_data};

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A new issue to a register retiring this cycle must win, so set follows clear.
  always_comb begin
    busy_next = busy;
    if (fifo_wr) busy_next[fifo_head.rd] = 1'b0;
    if (iss_set) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we   <= 1'b0;
      rf_rw   <= '0;
      rf_busw <= '0;
    end else begin
      rf_we <= alu_sel || fifo_wr;
      if (alu_sel) begin
        rf_rw   <= alu_rd;
        rf_busw <= alu_data;
      end else if (fifo_wr) begin
        rf_rw   <= fifo_head.rd;
        rf_busw <= fifo_head.data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_seq.sv
// Self-checking bench for regfile_wb_seq: expected register writes are queued
// as stimulus is driven and compared whenever the DUT asserts rf_we.
module tb_regfile_wb_seq;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   alu_valid;
  logic [REG_AW-1:0]      alu_rd;
  logic [XLEN-1:0]        alu_data;
  logic                   lsu_valid;
  logic                   lsu_ready;
  logic [REG_AW-1:0]      lsu_rd;
  logic [XLEN-1:0]        lsu_data;
  logic                   iss_valid;
  logic [REG_AW-1:0]      iss_rd;
  logic                   rf_we;
  logic [REG_AW-1:0]      rf_rw;
  logic [XLEN-1:0]        rf_busw;
  logic [NREGS-1:0]       busy;
  logic [$clog2(DEPTH):0] fifo_count;

  int total = 0;
  int bad   = 0;

  wb_entry exp_q[$];

  logic              chk_pend = 1'b0;
  logic [REG_AW-1:0] chk_rd   = '0;

  regfile_wb_seq #(
    .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .rf_we      (rf_we),
    .rf_rw      (rf_rw),
    .rf_busw    (rf_busw),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Every committed write must match the next queued expectation; an issue to a
  // busy register is only legal when that register retires in the same cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_we) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_write: rd=%0d data=%h, required no write", rf_rw, rf_busw);
        end else begin
          wb_entry e;
          e = exp_q.pop_front();
          if (rf_rw !== e.rd || rf_busw !== e.data) begin
            bad++;
            $display("[TB] FAIL write_order: got rd=%0d data=%h, required rd=%0d data=%h",
                     rf_rw, rf_busw, e.rd, e.data);
          end
        end
      end
      if (chk_pend) begin
        total++;
        if (!(rf_we === 1'b1 && rf_rw === chk_rd)) begin
          bad++;
          $display("[TB] FAIL illegal_issue: rd=%0d issued while busy, rf_we=%b rf_rw=%0d, required retire of rd=%0d",
                   chk_rd, rf_we, rf_rw, chk_rd);
        end
      end
      chk_pend = iss_valid && (iss_rd != '0) && busy[iss_rd];
      chk_rd   = iss_rd;
    end else begin
      chk_pend = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    lsu_valid = 1'b0;
    lsu_rd    = '0;
    lsu_data  = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    total++;
    if (rf_we !== 1'b0 || rf_rw !== '0 || rf_busw !== '0) begin
      bad++;
      $display("[TB] FAIL reset_rf: we=%b rw=%0d busw=%h, required 0/0/0", rf_we, rf_rw, rf_busw);
    end
    total++;
    if (busy !== '0 || fifo_count !== '0 || lsu_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_state: busy=%h count=%0d ready=%b, required 0/0/1", busy, fifo_count, lsu_ready);
    end
    #10;
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    step();
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEADBEEF;
    exp_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    step();
    idle_inputs();
    total++;
    if (rf_we !== 1'b1 || rf_rw !== 5'd5 || rf_busw !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL alu_write: we=%b rw=%0d busw=%h, required 1/5/deadbeef", rf_we, rf_rw, rf_busw);
    end
    step();
    total++;
    if (rf_we !== 1'b0) begin
      bad++;
      $display("[TB] FAIL alu_pulse: we=%b, required 0", rf_we);
    end
  endtask

  task automatic test_issue_retire();
    step();
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    step();
    idle_inputs();
    total++;
    if (busy !== 32'h0000_0080) begin
      bad++;
      $display("[TB] FAIL busy_set: busy=%h, required 00000080", busy);
    end
    lsu_valid = 1'b1;
    lsu_rd    = 5'd7;
    lsu_data  = 32'h0000_1234;
    exp_q.push_back('{rd: 5'd7, data: 32'h0000_1234});
    step();
    idle_inputs();
    step();
    total++;
    if (rf_we !== 1'b1 || rf_rw !== 5'd7 || rf_busw !== 32'h0000_1234 || busy[7] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL lsu_retire: we=%b rw=%0d busw=%h busy7=%b, required 1/7/00001234/0",
               rf_we, rf_rw, rf_busw, busy[7]);
    end
  endtask

  task automatic test_backpressure();
    wb_entry lsu_exp[$];
    bit      accepted;
    for (int i = 0; i < 6; i++) begin
      step();
      alu_valid = 1'b1;
      alu_rd    = REG_AW'(i + 1);
      alu_data  = 32'hA000_0000 + i;
      exp_q.push_back('{rd: REG_AW'(i + 1), data: 32'hA000_0000 + i});
      lsu_valid = 1'b1;
      if (i < 4) begin
        lsu_rd   = REG_AW'(10 + i);
        lsu_data = 32'hB000_0000 + i;
        lsu_exp.push_back('{rd: REG_AW'(10 + i), data: 32'hB000_0000 + i});
      end else begin
        lsu_rd   = 5'd14;
        lsu_data = 32'hB000_0004;
        total++;
        if (lsu_ready !== 1'b0 || fifo_count !== 3'd4) begin
          bad++;
          $display("[TB] FAIL fifo_full: ready=%b count=%0d, required 0/4", lsu_ready, fifo_count);
        end
      end
    end
    step();
    alu_valid = 1'b0;
    lsu_exp.push_back('{rd: 5'd14, data: 32'hB000_0004});
    while (lsu_exp.size() > 0) exp_q.push_back(lsu_exp.pop_front());
    accepted = 1'b0;
    for (int k = 0; k < 8 && !accepted; k++) begin
      if (lsu_ready === 1'b1) accepted = 1'b1;
      step();
    end
    idle_inputs();
    total++;
    if (!accepted) begin
      bad++;
      $display("[TB] FAIL stalled_push: fifth entry accepted=%b, required 1", accepted);
    end
    repeat (8) step();
    total++;
    if (exp_q.size() != 0 || fifo_count !== '0) begin
      bad++;
      $display("[TB] FAIL drain: pending=%0d count=%0d, required 0/0", exp_q.size(), fifo_count);
    end
  endtask

  task automatic test_alu_x0();
    step();
    lsu_valid = 1'b1;
    lsu_rd    = 5'd20;
    lsu_data  = 32'hCAFE_0020;
    exp_q.push_back('{rd: 5'd20, data: 32'hCAFE_0020});
    step();
    lsu_rd    = 5'd0;
    lsu_data  = 32'hBAD0_0000;
    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    alu_data  = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    total++;
    if (rf_we !== 1'b1 || rf_rw !== 5'd20 || rf_busw !== 32'hCAFE_0020) begin
      bad++;
      $display("[TB] FAIL alu_x0_drain: we=%b rw=%0d busw=%h, required 1/20/cafe0020", rf_we, rf_rw, rf_busw);
    end
    step();
    total++;
    if (rf_we !== 1'b0 || fifo_count !== '0 || busy !== '0) begin
      bad++;
      $display("[TB] FAIL head_x0: we=%b count=%0d busy=%h, required 0/0/0", rf_we, fifo_count, busy);
    end
  endtask

  task automatic test_set_wins();
    step();
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    step();
    idle_inputs();
    lsu_valid = 1'b1;
    lsu_rd    = 5'd9;
    lsu_data  = 32'h0000_0009;
    exp_q.push_back('{rd: 5'd9, data: 32'h0000_0009});
    step();
    idle_inputs();
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    step();
    idle_inputs();
    total++;
    if (rf_we !== 1'b1 || rf_rw !== 5'd9 || busy[9] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL set_wins: we=%b rw=%0d busy9=%b, required 1/9/1", rf_we, rf_rw, busy[9]);
    end
    lsu_valid = 1'b1;
    lsu_rd    = 5'd9;
    lsu_data  = 32'h0000_0909;
    exp_q.push_back('{rd: 5'd9, data: 32'h0000_0909});
    step();
    idle_inputs();
    step();
    total++;
    if (busy !== '0 || rf_rw !== 5'd9 || rf_busw !== 32'h0000_0909) begin
      bad++;
      $display("[TB] FAIL second_retire: busy=%h rw=%0d busw=%h, required 0/9/00000909", busy, rf_rw, rf_busw);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      alu_valid = 1'b1;
      alu_rd    = REG_AW'(i + 1);
      alu_data  = 32'hC000_0000 + i;
      exp_q.push_back('{rd: REG_AW'(i + 1), data: 32'hC000_0000 + i});
      lsu_valid = 1'b1;
      lsu_rd    = REG_AW'(3 + i);
      lsu_data  = 32'hD000_0000 + i;
      iss_valid = (i == 0);
      iss_rd    = 5'd3;
    end
    step();
    idle_inputs();
    total++;
    if (fifo_count !== 3'd3 || rf_we !== 1'b1 || busy[3] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pre_reset: count=%0d we=%b busy3=%b, required 3/1/1", fifo_count, rf_we, busy[3]);
    end
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    total++;
    if (fifo_count !== '0 || busy !== '0 || rf_we !== 1'b0 || lsu_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL async_reset: count=%0d busy=%h we=%b ready=%b, required 0/0/0/1",
               fifo_count, busy, rf_we, lsu_ready);
    end
    #5;
    rst_n = 1'b1;
    repeat (6) step();
    total++;
    if (fifo_count !== '0 || rf_we !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL post_reset: count=%0d we=%b pending=%0d, required 0/0/0",
               fifo_count, rf_we, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_issue_retire();
    test_backpressure();
    test_alu_x0();
    test_set_wins();
    test_mid_reset();
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
